// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// Holds the FSM state enum, trap cause codes and the select-width helper.
package pc_pkg;

    typedef enum logic {ST_RUN, ST_TRAP} state_t;

    localparam logic [1:0] CAUSE_OPCODE = 2'd0;
    localparam logic [1:0] CAUSE_OVF    = 2'd1;
    localparam logic [1:0] CAUSE_DIV0   = 2'd2;
    localparam logic [1:0] CAUSE_ALIGN  = 2'd3;

    // A single source still needs a one-bit select so the port never collapses.
    function automatic int selw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/datapath bundle between the main control FSM and the PC sequencer.
interface pc_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int NSRC  = 5
) ();
    import pc_pkg::*;

    localparam int SELW = selw(NSRC);

    logic [NSRC*WIDTH-1:0] src_bus;
    logic [SELW-1:0]       pc_sel;
    logic                  pc_write;
    logic                  pc_write_cond;
    logic                  cond_true;
    logic                  eret;
    logic                  exc_req;
    logic [1:0]            exc_code;
    logic [WIDTH-1:0]      next_pc;
    logic [WIDTH-1:0]      pc_out;
    logic [WIDTH-1:0]      epc_out;
    logic [1:0]            cause_out;
    logic                  trap_busy;
    logic                  pc_updated;

    modport master (
        output src_bus, pc_sel, pc_write, pc_write_cond, cond_true, eret, exc_req, exc_code,
        input  next_pc, pc_out, epc_out, cause_out, trap_busy, pc_updated
    );

    modport slave (
        input  src_bus, pc_sel, pc_write, pc_write_cond, cond_true, eret, exc_req, exc_code,
        output next_pc, pc_out, epc_out, cause_out, trap_busy, pc_updated
    );

endinterface

// File: rtl/pc_sequencer_src_mux.sv
// N-way next-PC source selector; out-of-range selects fall back to the last source.
module pc_src_mux
    import pc_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NSRC  = 5
) (
    input  logic [NSRC*WIDTH-1:0]   src_bus,
    input  logic [selw(NSRC)-1:0]   sel,
    output logic [WIDTH-1:0]        y
);

    always_comb begin
        y = src_bus[(NSRC-1)*WIDTH +: WIDTH];
        for (int i = 0; i < NSRC; i++) begin
            if (int'(sel) == i) begin
                y = src_bus[i*WIDTH +: WIDTH];
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: source select, PC/EPC registers, exception vectoring
// and a fixed-length trap window during which control requests are dropped.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               NSRC        = 5,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter logic [WIDTH-1:0] VEC_BASE    = WIDTH'(32'h0000_00FD),
    parameter int               VEC_STRIDE  = 1,
    parameter int               TRAP_HOLD   = 2,
    parameter bit               ALIGN_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    pc_sequencer_if.slave bus
);

    localparam int           HW        = (TRAP_HOLD > 1) ? $clog2(TRAP_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(TRAP_HOLD - 1);

    state_t           state, state_nxt;
    logic [HW-1:0]    hold, hold_nxt;
    logic [WIDTH-1:0] pc, pc_nxt;
    logic [WIDTH-1:0] epc, epc_nxt;
    logic [1:0]       cause, cause_nxt;
    logic             updated, updated_nxt;
    logic [WIDTH-1:0] next_pc;
    logic             load;
    logic             misalign;

    // Vector arithmetic wraps modulo 2^WIDTH by construction.
    function automatic logic [WIDTH-1:0] vec_addr(input logic [1:0] code);
        return VEC_BASE + WIDTH'(VEC_STRIDE) * WIDTH'(code);
    endfunction

    pc_src_mux #(
        .WIDTH (WIDTH),
        .NSRC  (NSRC)
    ) u_src_mux (
        .src_bus (bus.src_bus),
        .sel     (bus.pc_sel),
        .y       (next_pc)
    );

    assign load     = bus.pc_write | (bus.pc_write_cond & bus.cond_true);
    assign misalign = ALIGN_CHECK & load & (next_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_RUN;
            hold    <= '0;
            pc      <= RESET_PC;
            epc     <= '0;
            cause   <= CAUSE_OPCODE;
            updated <= 1'b0;
        end else begin
            state   <= state_nxt;
            hold    <= hold_nxt;
            pc      <= pc_nxt;
            epc     <= epc_nxt;
            cause   <= cause_nxt;
            updated <= updated_nxt;
        end
    end

    // Exceptions outrank misalignment, which outranks eret, which outranks a plain load.
    always_comb begin
        state_nxt   = state;
        hold_nxt    = hold;
        pc_nxt      = pc;
        epc_nxt     = epc;
        cause_nxt   = cause;
        updated_nxt = 1'b0;
        if (state == ST_RUN) begin
            if (bus.exc_req) begin
                epc_nxt     = pc;
                cause_nxt   = bus.exc_code;
                pc_nxt      = vec_addr(bus.exc_code);
                state_nxt   = ST_TRAP;
                hold_nxt    = '0;
                updated_nxt = 1'b1;
            end else if (misalign) begin
                epc_nxt     = pc;
                cause_nxt   = CAUSE_ALIGN;
                pc_nxt      = vec_addr(CAUSE_ALIGN);
                state_nxt   = ST_TRAP;
                hold_nxt    = '0;
                updated_nxt = 1'b1;
            end else if (bus.eret) begin
                pc_nxt      = epc;
                updated_nxt = 1'b1;
            end else if (load) begin
                pc_nxt      = next_pc;
                updated_nxt = 1'b1;
            end
        end else begin
            if (hold == HOLD_LAST) begin
                state_nxt = ST_RUN;
                hold_nxt  = '0;
            end else begin
                hold_nxt = hold + 1'b1;
            end
        end
    end

    assign bus.next_pc    = next_pc;
    assign bus.pc_out     = pc;
    assign bus.epc_out    = epc;
    assign bus.cause_out  = cause;
    assign bus.trap_busy  = (state == ST_TRAP);
    assign bus.pc_updated = updated;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer with hand-computed expectations
// (RESET_PC=0x400, vectors at 0xFD + code).
module tb_pc_sequencer;

    logic clk;
    logic reset;
    logic [31:0] src [5];
    int total;
    int bad;

    pc_sequencer_if #(.WIDTH(32), .NSRC(5)) ifc ();

    pc_sequencer #(
        .WIDTH       (32),
        .NSRC        (5),
        .RESET_PC    (32'h0000_0400),
        .VEC_BASE    (32'h0000_00FD),
        .VEC_STRIDE  (1),
        .TRAP_HOLD   (2),
        .ALIGN_CHECK (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    assign ifc.src_bus = {src[4], src[3], src[2], src[1], src[0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of control inputs, then controls return to idle; checks follow at edge+1.
    task automatic applyStimulus(input logic pw, input logic pwc, input logic ct,
                                 input logic er, input logic ex, input logic [1:0] code,
                                 input logic [2:0] sel);
        ifc.pc_write      = pw;
        ifc.pc_write_cond = pwc;
        ifc.cond_true     = ct;
        ifc.eret          = er;
        ifc.exc_req       = ex;
        ifc.exc_code      = code;
        ifc.pc_sel        = sel;
        @(posedge clk);
        #1;
        ifc.pc_write      = 1'b0;
        ifc.pc_write_cond = 1'b0;
        ifc.cond_true     = 1'b0;
        ifc.eret          = 1'b0;
        ifc.exc_req       = 1'b0;
        ifc.exc_code      = 2'd0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        src[0] = 32'h0000_0044;
        src[1] = 32'h0000_1002;
        src[2] = 32'h0000_0080;
        src[3] = 32'h0000_1000;
        src[4] = 32'h0000_2000;
        ifc.pc_sel        = 3'd0;
        ifc.pc_write      = 1'b0;
        ifc.pc_write_cond = 1'b0;
        ifc.cond_true     = 1'b0;
        ifc.eret          = 1'b0;
        ifc.exc_req       = 1'b0;
        ifc.exc_code      = 2'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc",    ifc.pc_out,            32'h400);
        checkOutput("rst_epc",   ifc.epc_out,           32'h0);
        checkOutput("rst_cause", 32'(ifc.cause_out),    32'd0);
        checkOutput("rst_busy",  32'(ifc.trap_busy),    32'd0);
        checkOutput("rst_upd",   32'(ifc.pc_updated),   32'd0);
        reset = 1'b0;

        ifc.pc_sel = 3'd3;
        #1;
        checkOutput("mux_sel3", ifc.next_pc, 32'h1000);
        ifc.pc_sel = 3'd7;
        #1;
        checkOutput("mux_sel7", ifc.next_pc, 32'h2000);

        applyStimulus(1, 0, 0, 0, 0, 2'd0, 3'd3);
        checkOutput("load_pc",  ifc.pc_out,          32'h1000);
        checkOutput("load_upd", 32'(ifc.pc_updated), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 3'd3);
        checkOutput("idle_pc",  ifc.pc_out,          32'h1000);
        checkOutput("idle_upd", 32'(ifc.pc_updated), 32'd0);

        applyStimulus(1, 0, 0, 0, 0, 2'd0, 3'd7);
        checkOutput("clamp_pc", ifc.pc_out, 32'h2000);

        applyStimulus(0, 1, 0, 0, 0, 2'd0, 3'd2);
        checkOutput("cond0_pc",  ifc.pc_out,          32'h2000);
        checkOutput("cond0_upd", 32'(ifc.pc_updated), 32'd0);
        applyStimulus(0, 1, 1, 0, 0, 2'd0, 3'd2);
        checkOutput("cond1_pc",  ifc.pc_out,          32'h80);
        checkOutput("cond1_upd", 32'(ifc.pc_updated), 32'd1);

        applyStimulus(1, 0, 0, 0, 0, 2'd0, 3'd0);
        checkOutput("pc44", ifc.pc_out, 32'h44);

        applyStimulus(1, 0, 0, 0, 1, 2'd1, 3'd0);
        checkOutput("exc_epc",   ifc.epc_out,          32'h44);
        checkOutput("exc_cause", 32'(ifc.cause_out),   32'd1);
        checkOutput("exc_pc",    ifc.pc_out,           32'hFE);
        checkOutput("exc_busy",  32'(ifc.trap_busy),   32'd1);
        checkOutput("exc_upd",   32'(ifc.pc_updated),  32'd1);
        applyStimulus(1, 0, 0, 1, 1, 2'd2, 3'd3);
        checkOutput("trap1_pc",   ifc.pc_out,          32'hFE);
        checkOutput("trap1_busy", 32'(ifc.trap_busy),  32'd1);
        checkOutput("trap1_upd",  32'(ifc.pc_updated), 32'd0);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 3'd3);
        checkOutput("trap2_pc",    ifc.pc_out,         32'hFE);
        checkOutput("trap2_busy",  32'(ifc.trap_busy), 32'd0);
        checkOutput("trap2_cause", 32'(ifc.cause_out), 32'd1);

        applyStimulus(1, 0, 0, 1, 0, 2'd0, 3'd3);
        checkOutput("eret_pc",    ifc.pc_out,          32'h44);
        checkOutput("eret_cause", 32'(ifc.cause_out),  32'd1);
        checkOutput("eret_epc",   ifc.epc_out,         32'h44);
        checkOutput("eret_upd",   32'(ifc.pc_updated), 32'd1);

        applyStimulus(1, 0, 0, 0, 0, 2'd0, 3'd3);
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 3'd3);
        checkOutput("same_pc",  ifc.pc_out,          32'h1000);
        checkOutput("same_upd", 32'(ifc.pc_updated), 32'd1);

        applyStimulus(0, 1, 0, 0, 0, 2'd0, 3'd1);
        checkOutput("nomis_pc",   ifc.pc_out,         32'h1000);
        checkOutput("nomis_busy", 32'(ifc.trap_busy), 32'd0);

        applyStimulus(1, 0, 0, 0, 0, 2'd0, 3'd1);
        checkOutput("mis_pc",    ifc.pc_out,         32'h100);
        checkOutput("mis_cause", 32'(ifc.cause_out), 32'd3);
        checkOutput("mis_epc",   ifc.epc_out,        32'h1000);
        checkOutput("mis_busy",  32'(ifc.trap_busy), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 3'd0);
        checkOutput("mis_done", 32'(ifc.trap_busy), 32'd0);

        applyStimulus(1, 0, 0, 0, 1, 2'd2, 3'd1);
        checkOutput("exmis_pc",    ifc.pc_out,         32'hFF);
        checkOutput("exmis_cause", 32'(ifc.cause_out), 32'd2);
        checkOutput("exmis_epc",   ifc.epc_out,        32'h100);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 3'd0);
        applyStimulus(0, 0, 0, 0, 0, 2'd0, 3'd0);

        applyStimulus(0, 0, 0, 0, 1, 2'd3, 3'd0);
        checkOutput("code3_pc",    ifc.pc_out,         32'h100);
        checkOutput("code3_cause", 32'(ifc.cause_out), 32'd3);
        checkOutput("code3_busy",  32'(ifc.trap_busy), 32'd1);

        reset = 1'b1;
        #1;
        checkOutput("midrst_pc",   ifc.pc_out,         32'h400);
        checkOutput("midrst_busy", 32'(ifc.trap_busy), 32'd0);
        checkOutput("midrst_epc",  ifc.epc_out,        32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        applyStimulus(1, 0, 0, 0, 0, 2'd0, 3'd3);
        checkOutput("postrst_pc",   ifc.pc_out,         32'h1000);
        checkOutput("postrst_busy", 32'(ifc.trap_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
